// File: rtl/s298_bist_driver.sv
// BIST driver for the s298 benchmark: LFSR-generated G0/G1/G2 stimulus,
// MISR compaction of the six s298 outputs, and golden-signature compare.
module s298_bist_driver #(
   parameter int unsigned NPAT     = 256,
   parameter int unsigned INIT_CYC = 16,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter logic [15:0] GOLDEN   = 16'h0000
) (
   input  logic        CK,
   input  logic        RST,
   input  logic        START,
   output logic        G0,
   output logic        G1,
   output logic        G2,
   input  logic        G66,
   input  logic        G67,
   input  logic        G117,
   input  logic        G118,
   input  logic        G132,
   input  logic        G133,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] SIG,
   output logic        PASS
);

   localparam logic [15:0] LP_SEED      = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LP_INIT_LAST = 16'(INIT_CYC - 1);
   localparam logic [15:0] LP_NPAT_LAST = 16'(NPAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_lfsr, w_lfsr_nxt, w_lfsr_step;
   logic [15:0] r_misr, w_misr_nxt, w_misr_step;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic        r_cap_vld;
   logic        r_g0, r_g1, r_g2;
   logic        w_g0_nxt, w_g1_nxt, w_g2_nxt;
   logic [5:0]  w_resp;

   assign w_resp      = {G133, G132, G118, G117, G67, G66};
   assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_misr_step = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]}
                        ^ {10'b0, w_resp};

   always_ff @(posedge CK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_lfsr    <= LP_SEED;
         r_misr    <= '0;
         r_cnt     <= '0;
         r_cap_vld <= 1'b0;
         r_g0      <= 1'b1;
         r_g1      <= 1'b0;
         r_g2      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lfsr    <= w_lfsr_nxt;
         r_misr    <= w_misr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cap_vld <= (r_state == S_RUN);
         r_g0      <= w_g0_nxt;
         r_g1      <= w_g1_nxt;
         r_g2      <= w_g2_nxt;
      end
   end

   // Response to RUN cycle k arrives one cycle later, so the MISR is gated
   // by the registered "was RUN" flag rather than by the current state.
   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_nxt  = r_lfsr;
      w_misr_nxt  = r_cap_vld ? w_misr_step : r_misr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (START) begin
               w_state_nxt = S_INIT;
               w_lfsr_nxt  = LP_SEED;
               w_misr_nxt  = '0;
               w_cnt_nxt   = '0;
            end
         end
         S_INIT: begin
            if (r_cnt == LP_INIT_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_RUN: begin
            w_lfsr_nxt = w_lfsr_step;
            if (r_cnt == LP_NPAT_LAST) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_FLUSH: w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase

      // Pin values are registered from the upcoming state and LFSR value.
      w_g0_nxt = 1'b1;
      w_g1_nxt = 1'b0;
      w_g2_nxt = 1'b0;
      if (w_state_nxt == S_RUN) begin
         w_g0_nxt = &w_lfsr_nxt[4:2];
         w_g1_nxt = w_lfsr_nxt[0];
         w_g2_nxt = w_lfsr_nxt[1];
      end
   end

   assign G0   = r_g0;
   assign G1   = r_g1;
   assign G2   = r_g2;
   assign BUSY = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_FLUSH);
   assign DONE = (r_state == S_DONE);
   assign SIG  = r_misr;
   assign PASS = DONE && (r_misr == GOLDEN);

endmodule
